// File: rtl/log_lanes.sv
// River log lanes: per-row frame counters step each row's logs left/right with screen wrap.
// Optional LOG_LANES_SPEEDUP_EN adds level_up and a saturating speed_level that shortens every period.
module log_lanes #(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_LOGS     = 1,
  parameter int SCREEN_WIDTH = 320,
  parameter int LOG_LEN      = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
`ifdef LOG_LANES_SPEEDUP_EN
  input  logic                                    level_up,
  output logic [3:0]                              speed_level,
`endif
  input  logic                                    run,
  input  logic                                    frame_tick,
  input  logic [0:NUM_ROWS-1][3:0]                row_period,
  output logic [0:NUM_ROWS-1][0:NUM_LOGS-1][9:0]  log_x,
  output logic [0:NUM_ROWS-1][0:NUM_LOGS-1][9:0]  log_width,
  output logic [0:NUM_ROWS-1]                     log_step,
  output logic [0:NUM_ROWS-1]                     log_dir
);

  localparam logic [9:0] X_MAX = 10'(SCREEN_WIDTH - 1);

  logic [3:0]                             frame_cnt_q [NUM_ROWS];
  logic [3:0]                             frame_cnt_d [NUM_ROWS];
  logic [3:0]                             period_eff  [NUM_ROWS];
  logic [0:NUM_ROWS-1]                    log_step_q, log_step_d;
  logic [0:NUM_ROWS-1][0:NUM_LOGS-1][9:0] log_x_q, log_x_d, log_x_init;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    assign log_dir[r] = 1'(r % 2);
    for (genvar i = 0; i < NUM_LOGS; i++) begin : g_log
      localparam int INIT = (i * (SCREEN_WIDTH / NUM_LOGS) + r * 16) % SCREEN_WIDTH;
      assign log_x_init[r][i] = 10'(INIT);
      assign log_width[r][i]  = 10'(LOG_LEN);
    end
  end

`ifdef LOG_LANES_SPEEDUP_EN
  logic [3:0] speed_level_q, speed_level_d;

  always_comb begin
    speed_level_d = speed_level_q;
    if (level_up && (speed_level_q != 4'd15)) speed_level_d = speed_level_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) speed_level_q <= 4'd0;
    else        speed_level_q <= speed_level_d;
  end

  assign speed_level = speed_level_q;

  // Period shrinks by the speed level but never drops below one frame.
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_period[r] > speed_level_q) period_eff[r] = row_period[r] - speed_level_q;
      else                               period_eff[r] = 4'd1;
    end
  end
`else
  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      period_eff[r] = (row_period[r] == 4'd0) ? 4'd1 : row_period[r];
    end
  end
`endif

  // A counter already past a newly shortened period steps on the next tick.
  always_comb begin
    log_x_d    = log_x_q;
    log_step_d = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      frame_cnt_d[r] = frame_cnt_q[r];
      if (run && frame_tick) begin
        if (frame_cnt_q[r] >= period_eff[r] - 4'd1) begin
          frame_cnt_d[r] = 4'd0;
          log_step_d[r]  = 1'b1;
          for (int i = 0; i < NUM_LOGS; i++) begin
            if (r % 2 == 0)
              log_x_d[r][i] = (log_x_q[r][i] == X_MAX) ? 10'd0 : log_x_q[r][i] + 10'd1;
            else
              log_x_d[r][i] = (log_x_q[r][i] == 10'd0) ? X_MAX : log_x_q[r][i] - 10'd1;
          end
        end else begin
          frame_cnt_d[r] = frame_cnt_q[r] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_ROWS; r++) frame_cnt_q[r] <= 4'd0;
      log_step_q <= '0;
      log_x_q    <= log_x_init;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) frame_cnt_q[r] <= frame_cnt_d[r];
      log_step_q <= log_step_d;
      log_x_q    <= log_x_d;
    end
  end

  assign log_x    = log_x_q;
  assign log_step = log_step_q;

endmodule

// File: tb/tb_log_lanes.sv
// Bench for log_lanes: directed vector table, wrap/freeze/reset sequences, random run vs position model.
module tb_log_lanes;
  localparam int NR = 4;
  localparam int NL = 1;
  localparam int W  = 320;

  logic                          clk = 1'b0;
  logic                          reset = 1'b0;
  logic                          run = 1'b0;
  logic                          frame_tick = 1'b0;
  logic                          level_up = 1'b0;
  logic [0:NR-1][3:0]            row_period = '0;
  logic [0:NR-1][0:NL-1][9:0]    log_x;
  logic [0:NR-1][0:NL-1][9:0]    log_width;
  logic [0:NR-1]                 log_step;
  logic [0:NR-1]                 log_dir;
`ifdef LOG_LANES_SPEEDUP_EN
  logic [3:0]                    speed_level;
`endif

  int vectors = 0;
  int fails   = 0;

  // Model: ticks seen since the row last moved, net steps taken, last-edge step flag.
  int since [NR];
  int steps [NR];
  logic exp_step [NR];
  int spd = 0;

  log_lanes dut (
    .clk        (clk),
    .reset      (reset),
`ifdef LOG_LANES_SPEEDUP_EN
    .level_up   (level_up),
    .speed_level(speed_level),
`endif
    .run        (run),
    .frame_tick (frame_tick),
    .row_period (row_period),
    .log_x      (log_x),
    .log_width  (log_width),
    .log_step   (log_step),
    .log_dir    (log_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_x(input int r, input int i);
    int init, d;
    init = (i * (W / NL) + r * 16) % W;
    d = (r % 2 == 0) ? steps[r] : -steps[r];
    return (((init + d) % W) + W) % W;
  endfunction

  function automatic int eff_period(input int r);
    int p;
    p = int'(row_period[r]);
`ifdef LOG_LANES_SPEEDUP_EN
    p = p - spd;
`endif
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_edge();
    for (int r = 0; r < NR; r++) begin
      if (!reset) begin
        since[r] = 0; steps[r] = 0; exp_step[r] = 1'b0;
      end else if (run && frame_tick) begin
        if (since[r] + 1 >= eff_period(r)) begin
          since[r] = 0; steps[r] = (steps[r] + 1) % W; exp_step[r] = 1'b1;
        end else begin
          since[r]++; exp_step[r] = 1'b0;
        end
      end else begin
        exp_step[r] = 1'b0;
      end
    end
`ifdef LOG_LANES_SPEEDUP_EN
    if (!reset) spd = 0;
    else if (level_up && spd < 15) spd++;
`endif
  endtask

  task automatic check_model();
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NL; i++)
        check($sformatf("model x[%0d][%0d]", r, i), int'(log_x[r][i]), exp_x(r, i));
      check($sformatf("model step[%0d]", r), int'(log_step[r]), int'(exp_step[r]));
    end
  endtask

  // Inputs are set by the caller; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; frame_tick = 1'b0; level_up = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       run;
    logic       tick;
    logic [3:0] per;
    int         x00;
    int         step0;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 4'd3, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'd3, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'd3, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'd3, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'd3, 1, 1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'd3, 1, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'd3, 1, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'd3, 2, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'd3, 2, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'd0, 2, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'd0, 3, 1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4'd1, 4, 1};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 4'd1, 0, 0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 4'd2, 0, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 4'd2, 1, 1};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 4'd4, 1, 0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 4'd1, 2, 1};

    for (int r = 0; r < NR; r++) begin
      since[r] = 0; steps[r] = 0; exp_step[r] = 1'b0;
    end

    // Reset state and constant outputs.
    do_reset();
    for (int r = 0; r < NR; r++) begin
      check($sformatf("reset x[%0d]", r), int'(log_x[r][0]), r * 16);
      check($sformatf("reset step[%0d]", r), int'(log_step[r]), 0);
      check($sformatf("width[%0d]", r), int'(log_width[r][0]), 64);
      check($sformatf("dir[%0d]", r), int'(log_dir[r]), r % 2);
    end

    // Directed table: period 3 stepping, freeze, period 0, reset with tick, period change.
    for (int k = 0; k < 17; k++) begin
      reset = tbl[k].rst_n; run = tbl[k].run; frame_tick = tbl[k].tick;
      row_period = {NR{tbl[k].per}};
      cycle();
      check($sformatf("tbl%0d x00", k), int'(log_x[0][0]), tbl[k].x00);
      check($sformatf("tbl%0d step0", k), int'(log_step[0]), tbl[k].step0);
    end

    // Wrap: row 1 left past 0, row 0 right past 319.
    do_reset();
    row_period = {NR{4'd1}}; run = 1'b1; frame_tick = 1'b1;
    for (int k = 0; k < 16; k++) cycle();
    check("row1 at zero", int'(log_x[1][0]), 0);
    cycle();
    check("row1 wrap left", int'(log_x[1][0]), 319);
    for (int k = 17; k < 319; k++) cycle();
    check("row0 at max", int'(log_x[0][0]), 319);
    cycle();
    check("row0 wrap right", int'(log_x[0][0]), 0);

    // Freeze with period 0, then a single running tick steps every row.
    do_reset();
    row_period = '0; run = 1'b0; frame_tick = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("frozen step", int'(log_step), 0);
    end
    check("frozen x0", int'(log_x[0][0]), 0);
    check("frozen x3", int'(log_x[3][0]), 48);
    run = 1'b1;
    cycle();
    check("all rows step", int'(log_step), 15);
    check("x after step r0", int'(log_x[0][0]), 1);
    check("x after step r1", int'(log_x[1][0]), 15);
    check("x after step r2", int'(log_x[2][0]), 33);
    check("x after step r3", int'(log_x[3][0]), 47);
    frame_tick = 1'b0;
    cycle();
    check("step drops", int'(log_step), 0);

`ifdef LOG_LANES_SPEEDUP_EN
    do_reset();
    row_period = {NR{4'd4}}; run = 1'b1; frame_tick = 1'b0;
    level_up = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    level_up = 1'b0; frame_tick = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("speedup step", int'(log_step), 15);
    end
    frame_tick = 1'b0; level_up = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    level_up = 1'b0;
    check("speed saturates", int'(speed_level), 15);
`endif

    // Random run against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      reset      = ($urandom_range(0, 149) != 0);
      run        = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      level_up   = ($urandom_range(0, 39) == 0);
      for (int r = 0; r < NR; r++)
        if ($urandom_range(0, 19) == 0)
          row_period[r] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                                       : 4'($urandom_range(0, 15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/log_lanes.md
LOG_LANES -- requirements
Module: log_lanes

Interface
REQ-001 Parameter NUM_ROWS, default 4: number of river rows driven.
REQ-002 Parameter NUM_LOGS, default 1: logs per row.
REQ-003 Parameter SCREEN_WIDTH, default 320: horizontal wrap modulus in pixels.
REQ-004 Parameter LOG_LEN, default 64: width of every log in pixels.
REQ-005 clk  input  1: single system clock; all state updates on its rising edge.
REQ-006 reset  input  1: synchronous reset, active-low; reset=0 at a rising clk edge resets the block.
REQ-007 run  input  1: 1 = lanes move; 0 = freeze all counters and positions.
REQ-008 frame_tick  input  1: one-cycle pulse per video frame.
REQ-009 row_period  input  [0:NUM_ROWS-1] x 4: frames per 1-pixel step for each row.
REQ-010 log_x  output  [0:NUM_ROWS-1][0:NUM_LOGS-1] x 10: left edge of each log, range 0..SCREEN_WIDTH-1.
REQ-011 log_width  output  [0:NUM_ROWS-1][0:NUM_LOGS-1] x 10: constant LOG_LEN.
REQ-012 log_step  output  [0:NUM_ROWS-1] x 1: registered one-cycle pulse; row moved on this edge.
REQ-013 log_dir  output  [0:NUM_ROWS-1] x 1: constant; 0 = moves right (even rows), 1 = moves left (odd rows).

Function
REQ-014 Each row SHALL hold a 4-bit frame counter frame_cnt[r].
REQ-015 The effective period SHALL be P[r] = max(1, row_period[r]); a period of 0 is treated as 1.
REQ-016 On an edge with reset=1, run=1 and frame_tick=1: if frame_cnt[r] >= P[r]-1, then frame_cnt[r] <= 0, the row steps, and log_step[r] <= 1.
REQ-017 Otherwise on that edge, frame_cnt[r] <= frame_cnt[r]+1 and log_step[r] <= 0.
REQ-018 log_step SHALL be 0 on every edge where frame_tick=0 or run=0.
REQ-019 A step SHALL update all logs of row r on the same edge that raises log_step[r]; latency from frame_tick to log_x change is exactly 1 cycle.
REQ-020 Right step: x <= (x == SCREEN_WIDTH-1) ? 0 : x+1.
REQ-021 Left step: x <= (x == 0) ? SCREEN_WIDTH-1 : x-1.
REQ-022 All position arithmetic SHALL be 10-bit unsigned with no overflow beyond SCREEN_WIDTH.
REQ-023 With run=0, frame_cnt and log_x SHALL hold.
REQ-024 row_period changes SHALL take effect at the next frame_tick without resetting the counter; a counter already >= P-1 steps on that tick.

Reset
REQ-025 On reset=0: frame_cnt[r] <= 0, log_step <= 0, and log_x[r][i] <= (i*(SCREEN_WIDTH/NUM_LOGS) + r*16) mod SCREEN_WIDTH.
REQ-026 Reset SHALL take priority over a simultaneous frame_tick or run.
REQ-027 Reset mid-step SHALL discard the pending step; no log_step pulse follows reset.

Configuration
REQ-028 Macro LOG_LANES_SPEEDUP_EN, when defined, SHALL add input level_up (1 bit, one-cycle pulse) and a 4-bit saturating speed_level register.
REQ-029 With the macro, speed_level SHALL reset to 0 and increment on each level_up pulse, saturating at 15.
REQ-030 With the macro, the effective period SHALL be P[r] = max(1, row_period[r] - speed_level), with no wrap below 1.
REQ-031 Without the macro, the level_up port and speed_level register SHALL be absent and REQ-015 applies unchanged.

Verification
REQ-032 Reset release with defaults: log_x = {0, 16, 32, 48}, log_step = 0, log_width = 64 for every log.
REQ-033 row_period[0]=3, run=1, 6 frame_ticks: log_step[0] pulses on ticks 3 and 6; log_x[0][0] goes 0->1->2.
REQ-034 Row 1 at x=0 (forced by 16 left steps with period 1), one more tick: log_x[1][0] = 319. Row 0 at x=319, one tick: log_x[0][0] = 0.
REQ-035 row_period=0, run=0, 5 ticks: no change and no log_step. Then run=1, 1 tick: every row steps once.
REQ-036 reset=0 asserted in the same cycle as frame_tick=1: positions equal the REQ-025 values and log_step = 0 on the following cycle.
REQ-037 With LOG_LANES_SPEEDUP_EN, row_period=4, 3 level_up pulses then 2 ticks: a step occurs on every tick (P=1). After 20 level_up pulses, speed_level = 15.
